// File: rtl/packing_controller.sv
// Sequencer for the stage-3 packing/shifting datapath: tracks pending accumulator bits and
// drives shift amounts plus store/output/fill/stop strobes, aborting lines that fail to compress.
//
// state | meaning
// IDLE  | leaving reset, no pairs accepted
// PACK  | accepting length pairs and emitting 64-bit chunks
// FLUSH | zero-pads the remaining pending bits into a final chunk
// STOP  | line aborted; pairs accepted and discarded until last
// DONE  | line complete; o_done pulse, counters cleared
module packing_controller #(
  parameter int CACHE_LINE    = 64,
  parameter int TOTAL_LENGTH  = 7,
  parameter int OUT_SHIFT_BIT = 7,
  parameter int WORD2_LENGTH  = 6,
  parameter int LINE_BITS     = 512,
  parameter int CNT_W         = 10
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic                     i_last,
  input  logic [WORD2_LENGTH-1:0]  i_len1,
  input  logic [WORD2_LENGTH-1:0]  i_len2,
  output logic [WORD2_LENGTH-1:0]  o_word2_length,
  output logic [TOTAL_LENGTH-1:0]  o_total_length,
  output logic [OUT_SHIFT_BIT-1:0] o_out_shift,
  output logic                     o_bubble,
  output logic                     o_store_flag,
  output logic                     o_output_flag,
  output logic                     o_fill_flag,
  output logic                     o_stop_flag,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic [CNT_W-1:0]         o_comp_bits,
  output logic                     o_done
);

  typedef enum logic [2:0] {IDLE, PACK, FLUSH, STOP, DONE} state_t;

  localparam logic [TOTAL_LENGTH:0] CHUNK    = (TOTAL_LENGTH+1)'(CACHE_LINE);
  localparam logic [CNT_W-1:0]      LINE_LIM = CNT_W'(LINE_BITS);

  state_t                  state, state_nxt;
  logic [TOTAL_LENGTH-1:0] p, p_nxt;
  logic [CNT_W-1:0]        c, c_nxt;
  logic                    k, k_nxt;
  logic                    abort_q, abort_nxt;
  logic                    out_flag_q, out_valid_q, out_valid_nxt;
  logic                    complete, aborting, stall;
  logic [TOTAL_LENGTH-1:0] s;
  logic [TOTAL_LENGTH:0]   pn, p_ext;
  logic [CNT_W-1:0]        c_sum;

  assign s     = TOTAL_LENGTH'(i_len1) + TOTAL_LENGTH'(i_len2);
  assign p_ext = (TOTAL_LENGTH+1)'(p);
  assign pn    = p_ext + (TOTAL_LENGTH+1)'(s);
  assign c_sum = c + CNT_W'(s);
  assign stall = out_valid_q & ~i_out_ready;

  always_comb begin
    state_nxt      = state;
    p_nxt          = p;
    c_nxt          = c;
    k_nxt          = k;
    abort_nxt      = abort_q;
    complete       = 1'b0;
    aborting       = 1'b0;
    o_ready        = 1'b0;
    o_word2_length = '0;
    o_total_length = '0;
    o_out_shift    = '0;
    o_bubble       = 1'b0;
    o_store_flag   = 1'b0;
    case (state)
      IDLE: state_nxt = PACK;
      PACK: begin
        o_ready = ~stall;
        if (i_valid && !stall) begin
          o_word2_length = i_len2;
          o_total_length = s;
          c_nxt          = c_sum;
          if (pn >= CHUNK) begin
            o_store_flag = 1'b1;
            o_out_shift  = OUT_SHIFT_BIT'(pn - CHUNK);
            p_nxt        = TOTAL_LENGTH'(pn - CHUNK);
            k_nxt        = ~k;
          end else begin
            p_nxt = TOTAL_LENGTH'(pn);
          end
          aborting = (c_sum > LINE_LIM);
          if (aborting) abort_nxt = 1'b1;
          // the aborted line is replaced by the backup, so its outputs are never latched
          complete = o_store_flag & k & ~aborting;
          if (i_last) begin
            if (aborting || p_nxt == '0) begin
              state_nxt = DONE;
              if (!aborting && k_nxt) complete = 1'b1;
            end else begin
              state_nxt = FLUSH;
            end
          end else if (aborting) begin
            state_nxt = STOP;
          end
        end
      end
      FLUSH: begin
        if (!stall) begin
          o_bubble     = 1'b1;
          o_store_flag = 1'b1;
          if (p_ext > CHUNK) begin
            // more than one chunk still pending: drain a full chunk and stay
            o_out_shift = OUT_SHIFT_BIT'(p_ext - CHUNK);
            p_nxt       = TOTAL_LENGTH'(p_ext - CHUNK);
            k_nxt       = ~k;
            complete    = k;
          end else begin
            o_total_length = TOTAL_LENGTH'(CHUNK - p_ext);
            p_nxt          = '0;
            k_nxt          = 1'b0;
            complete       = 1'b1;
            state_nxt      = DONE;
          end
        end
      end
      STOP: begin
        o_ready = ~stall;
        if (i_valid && !stall && i_last) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = PACK;
        p_nxt     = '0;
        c_nxt     = '0;
        k_nxt     = 1'b0;
        abort_nxt = 1'b0;
      end
      default: state_nxt = IDLE;
    endcase
    out_valid_nxt = complete ? 1'b1 : (i_out_ready ? 1'b0 : out_valid_q);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= IDLE;
      p           <= '0;
      c           <= '0;
      k           <= 1'b0;
      abort_q     <= 1'b0;
      out_flag_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      p           <= p_nxt;
      c           <= c_nxt;
      k           <= k_nxt;
      abort_q     <= abort_nxt;
      out_flag_q  <= complete;
      out_valid_q <= out_valid_nxt;
    end
  end

  assign o_output_flag = out_flag_q;
  assign o_out_valid   = out_valid_q;
  assign o_stop_flag   = abort_q;
  assign o_done        = (state == DONE);
  assign o_fill_flag   = (state == DONE) & abort_q;
  assign o_comp_bits   = c;

endmodule
